// File: rtl/axils_pkg.sv
// ============================================================================
// Module      : axils_pkg
// Description : Shared types and constants for the AXI4-Lite slave bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axils_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ACC  = 3'd1,
        RD_ACC  = 3'd2,
        WR_RESP = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    // Read data returned when the local bus never acknowledges
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/axils_acc_timer.sv
// ============================================================================
// Module      : axils_acc_timer
// Description : Loadable watchdog counter with clear, enable and expiry flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axils_acc_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + c_one;
        end
    end

    // Fires during the enabled cycle that brings the count up to the limit; limit 0 disables
    assign o_expired = i_en && (i_limit != '0) && (r_count == i_limit - c_one);

endmodule

`default_nettype wire

// File: rtl/axils.sv
// ============================================================================
// Module      : axils
// Description : AXI4-Lite slave bridging to a single-access req/ack register bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axils
    import axils_pkg::*;
#(
    parameter logic [31:0] ADDR_SIZE      = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] AWADDR,
    input  logic [2:0]  AWPROT,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP,
    input  logic [31:0] ARADDR,
    input  logic [2:0]  ARPROT,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        REG_REQ,
    output logic        REG_WE,
    output logic [31:0] REG_ADDR,
    output logic [3:0]  REG_WSTB,
    output logic [31:0] REG_WDATA,
    input  logic        REG_ACK,
    input  logic [31:0] REG_RDATA,
    input  logic        REG_ERR
);

    localparam logic [31:0] c_timeout = 32'(TIMEOUT_CYCLES);

    state_t      r_state, w_state_nx;
    logic        r_aw_full, r_w_full, r_ar_full;
    logic        r_awready, r_wready, r_arready;
    logic [31:0] r_aw_addr, r_w_data, r_ar_addr;
    logic [3:0]  r_w_strb;
    logic        r_prefer_rd, w_prefer_rd_nx;
    logic        r_reg_req, w_reg_req_nx, r_reg_we, w_reg_we_nx;
    logic [31:0] r_reg_addr, w_reg_addr_nx, r_reg_wdata, w_reg_wdata_nx;
    logic [3:0]  r_reg_wstb, w_reg_wstb_nx;
    logic        r_bvalid, w_bvalid_nx, r_rvalid, w_rvalid_nx;
    resp_t       r_bresp, w_bresp_nx, r_rresp, w_rresp_nx;
    logic [31:0] r_rdata, w_rdata_nx;
    logic        w_free_wr, w_free_rd, w_expired;

    logic w_unused_prot;
    assign w_unused_prot = ^{AWPROT, ARPROT};

    // Handshakes bypass the buffers so an idle FSM can start the access immediately
    logic        w_aw_hs, w_w_hs, w_ar_hs;
    logic        w_wr_rdy, w_rd_rdy;
    logic [31:0] w_aw_addr, w_w_data, w_ar_addr;
    logic [3:0]  w_w_strb;
    logic        w_aw_full_nx, w_w_full_nx, w_ar_full_nx;

    assign w_aw_hs   = AWVALID && r_awready;
    assign w_w_hs    = WVALID && r_wready;
    assign w_ar_hs   = ARVALID && r_arready;
    assign w_aw_addr = r_aw_full ? r_aw_addr : AWADDR;
    assign w_w_data  = r_w_full ? r_w_data : WDATA;
    assign w_w_strb  = r_w_full ? r_w_strb : WSTRB;
    assign w_ar_addr = r_ar_full ? r_ar_addr : ARADDR;
    assign w_wr_rdy  = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
    assign w_rd_rdy  = r_ar_full || w_ar_hs;

    assign w_aw_full_nx = (r_aw_full || w_aw_hs) && !w_free_wr;
    assign w_w_full_nx  = (r_w_full || w_w_hs) && !w_free_wr;
    assign w_ar_full_nx = (r_ar_full || w_ar_hs) && !w_free_rd;

    axils_acc_timer #(.WIDTH(32)) u_timer (
        .clk        (ACLK),
        .rst        (ARESET),
        .i_clr      ((r_state != WR_ACC) && (r_state != RD_ACC)),
        .i_load     (1'b0),
        .i_load_val (32'h0),
        .i_en       (r_reg_req),
        .i_limit    (c_timeout),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_prefer_rd_nx = r_prefer_rd;
        w_reg_req_nx   = r_reg_req;
        w_reg_we_nx    = r_reg_we;
        w_reg_addr_nx  = r_reg_addr;
        w_reg_wstb_nx  = r_reg_wstb;
        w_reg_wdata_nx = r_reg_wdata;
        w_bvalid_nx    = r_bvalid;
        w_bresp_nx     = r_bresp;
        w_rvalid_nx    = r_rvalid;
        w_rresp_nx     = r_rresp;
        w_rdata_nx     = r_rdata;
        w_free_wr      = 1'b0;
        w_free_rd      = 1'b0;
        case (r_state)
            IDLE: begin
                // The round-robin bit only moves when both directions contend
                if (w_wr_rdy && (!w_rd_rdy || !r_prefer_rd)) begin
                    if (w_rd_rdy) w_prefer_rd_nx = 1'b1;
                    if (w_aw_addr >= ADDR_SIZE) begin
                        w_state_nx  = WR_RESP;
                        w_bvalid_nx = 1'b1;
                        w_bresp_nx  = DECERR;
                        w_free_wr   = 1'b1;
                    end else begin
                        w_state_nx     = WR_ACC;
                        w_reg_req_nx   = 1'b1;
                        w_reg_we_nx    = 1'b1;
                        w_reg_addr_nx  = w_aw_addr;
                        w_reg_wstb_nx  = w_w_strb;
                        w_reg_wdata_nx = w_w_data;
                    end
                end else if (w_rd_rdy) begin
                    if (w_wr_rdy) w_prefer_rd_nx = 1'b0;
                    if (w_ar_addr >= ADDR_SIZE) begin
                        w_state_nx  = RD_RESP;
                        w_rvalid_nx = 1'b1;
                        w_rresp_nx  = DECERR;
                        w_rdata_nx  = 32'h0;
                        w_free_rd   = 1'b1;
                    end else begin
                        w_state_nx    = RD_ACC;
                        w_reg_req_nx  = 1'b1;
                        w_reg_we_nx   = 1'b0;
                        w_reg_addr_nx = w_ar_addr;
                        w_reg_wstb_nx = 4'h0;
                    end
                end
            end
            WR_ACC: begin
                if (REG_ACK || w_expired) begin
                    w_state_nx   = WR_RESP;
                    w_reg_req_nx = 1'b0;
                    w_bvalid_nx  = 1'b1;
                    w_bresp_nx   = (REG_ACK && !REG_ERR) ? OKAY : SLVERR;
                    w_free_wr    = 1'b1;
                end
            end
            RD_ACC: begin
                if (REG_ACK || w_expired) begin
                    w_state_nx   = RD_RESP;
                    w_reg_req_nx = 1'b0;
                    w_rvalid_nx  = 1'b1;
                    w_rresp_nx   = (REG_ACK && !REG_ERR) ? OKAY : SLVERR;
                    w_rdata_nx   = REG_ACK ? REG_RDATA : TIMEOUT_RDATA;
                    w_free_rd    = 1'b1;
                end
            end
            WR_RESP: begin
                if (BREADY) begin
                    w_bvalid_nx = 1'b0;
                    w_state_nx  = IDLE;
                end
            end
            RD_RESP: begin
                if (RREADY) begin
                    w_rvalid_nx = 1'b0;
                    w_state_nx  = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_prefer_rd <= 1'b0;
            r_aw_full   <= 1'b0;
            r_w_full    <= 1'b0;
            r_ar_full   <= 1'b0;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_arready   <= 1'b0;
            r_aw_addr   <= 32'h0;
            r_w_data    <= 32'h0;
            r_w_strb    <= 4'h0;
            r_ar_addr   <= 32'h0;
            r_reg_req   <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_addr  <= 32'h0;
            r_reg_wstb  <= 4'h0;
            r_reg_wdata <= 32'h0;
            r_bvalid    <= 1'b0;
            r_bresp     <= OKAY;
            r_rvalid    <= 1'b0;
            r_rresp     <= OKAY;
            r_rdata     <= 32'h0;
        end else begin
            r_state     <= w_state_nx;
            r_prefer_rd <= w_prefer_rd_nx;
            r_aw_full   <= w_aw_full_nx;
            r_w_full    <= w_w_full_nx;
            r_ar_full   <= w_ar_full_nx;
            r_awready   <= !w_aw_full_nx;
            r_wready    <= !w_w_full_nx;
            r_arready   <= !w_ar_full_nx;
            if (w_aw_hs) r_aw_addr <= AWADDR;
            if (w_w_hs) begin
                r_w_data <= WDATA;
                r_w_strb <= WSTRB;
            end
            if (w_ar_hs) r_ar_addr <= ARADDR;
            r_reg_req   <= w_reg_req_nx;
            r_reg_we    <= w_reg_we_nx;
            r_reg_addr  <= w_reg_addr_nx;
            r_reg_wstb  <= w_reg_wstb_nx;
            r_reg_wdata <= w_reg_wdata_nx;
            r_bvalid    <= w_bvalid_nx;
            r_bresp     <= w_bresp_nx;
            r_rvalid    <= w_rvalid_nx;
            r_rresp     <= w_rresp_nx;
            r_rdata     <= w_rdata_nx;
        end
    end

    assign AWREADY   = r_awready;
    assign WREADY    = r_wready;
    assign ARREADY   = r_arready;
    assign BVALID    = r_bvalid;
    assign BRESP     = r_bresp;
    assign RVALID    = r_rvalid;
    assign RRESP     = r_rresp;
    assign RDATA     = r_rdata;
    assign REG_REQ   = r_reg_req;
    assign REG_WE    = r_reg_we;
    assign REG_ADDR  = r_reg_addr;
    assign REG_WSTB  = r_reg_wstb;
    assign REG_WDATA = r_reg_wdata;

endmodule

`default_nettype wire

// File: tb/tb_axils.sv
// ============================================================================
// Module      : tb_axils
// Description : Randomized self-checking bench for the axils AXI4-Lite bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axils;

    localparam int          TO       = 8;
    localparam logic [31:0] WIN_SIZE = 32'h0000_1000;

    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0, REG_RDATA = '0;
    logic [2:0]  AWPROT = '0, ARPROT = '0;
    logic [3:0]  WSTRB = '0;
    logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic        REG_ACK = 0, REG_ERR = 0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, REG_REQ, REG_WE;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA, REG_ADDR, REG_WDATA;
    logic [3:0]  REG_WSTB;

    axils #(.ADDR_SIZE(WIN_SIZE), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .REG_REQ(REG_REQ), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR), .REG_WSTB(REG_WSTB),
        .REG_WDATA(REG_WDATA), .REG_ACK(REG_ACK), .REG_RDATA(REG_RDATA), .REG_ERR(REG_ERR)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0, n_err = 0, cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Local register device and its behaviour knobs
    logic [31:0] dev_mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          rsp_delay = 0;
    bit          rsp_err = 0, rsp_noack = 0;
    bit          in_req = 0;
    int          req_len = 0, req_first_cyc = 0, req_last_cyc = 0, acc_cnt = 0;
    logic        acc_we;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_wstb;
    bit          we_log [$];
    bit          prefer_read = 0;

    always @(negedge ACLK) begin
        int idx;
        REG_ACK   = 1'b0;
        REG_ERR   = 1'b0;
        REG_RDATA = $urandom;
        if (ARESET) begin
            in_req = 0;
        end else if (REG_REQ) begin
            if (!in_req) begin
                in_req = 1; req_len = 0; req_first_cyc = cyc; acc_cnt++;
                acc_we = REG_WE; acc_addr = REG_ADDR; acc_wstb = REG_WSTB; acc_wdata = REG_WDATA;
                we_log.push_back(REG_WE);
            end
            req_len++;
            req_last_cyc = cyc;
            if (!rsp_noack && req_len == rsp_delay + 1) begin
                idx       = int'(REG_ADDR[11:2]);
                REG_ACK   = 1'b1;
                REG_ERR   = rsp_err;
                REG_RDATA = dev_mem[idx];
                if (REG_WE && !rsp_err)
                    for (int b = 0; b < 4; b++)
                        if (REG_WSTB[b]) dev_mem[idx][8*b +: 8] = REG_WDATA[8*b +: 8];
            end
        end else begin
            in_req = 0;
        end
    end

    function automatic logic [1:0] exp_resp(input bit in_rng, input bit err, input bit noack);
        if (!in_rng) return 2'b11;
        if (noack || err) return 2'b10;
        return 2'b00;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input int dly, input bit err, input bit noack);
        bit aw_go = 0, w_go = 0, aw_done = 0, w_done = 0, stable = 1, in_rng;
        int aw_hs = 0, w_hs = 0, last_hs, acc0, k, bv_cyc, idx;
        logic [1:0] er;
        rsp_delay = dly; rsp_err = err; rsp_noack = noack;
        in_rng = addr < WIN_SIZE;
        er     = exp_resp(in_rng, err, noack);
        acc0   = acc_cnt;
        k      = 0;
        while (!(aw_done && w_done) && k < 100) begin
            @(negedge ACLK);
            if (aw_go) begin AWVALID = 0; aw_go = 0; aw_done = 1; end
            if (w_go)  begin WVALID = 0;  w_go = 0;  w_done = 1;  end
            if (!aw_done && !aw_go && k >= aw_dly) begin
                AWVALID = 1; AWADDR = addr;
                if (AWREADY) begin aw_go = 1; aw_hs = cyc; end
            end
            if (!w_done && !w_go && k >= w_dly) begin
                WVALID = 1; WDATA = data; WSTRB = strb;
                if (WREADY) begin w_go = 1; w_hs = cyc; end
            end
            k++;
        end
        check_val("wr_handshake", {aw_done, w_done}, 2'b11);
        last_hs = (aw_hs > w_hs) ? aw_hs : w_hs;
        k = 0;
        while (!BVALID && k < 50) begin @(negedge ACLK); k++; end
        bv_cyc = cyc;
        check_val("wr_bvalid", BVALID, 1);
        check_val("wr_bresp", BRESP, er);
        if (in_rng) begin
            check_val("wr_acc_cnt", acc_cnt - acc0, 1);
            check_val("wr_req_start", req_first_cyc, last_hs + 1);
            check_val("wr_acc_fields", {acc_we, acc_addr, acc_wstb, acc_wdata}, {1'b1, addr, strb, data});
            check_val("wr_req_len", req_len, noack ? TO : dly + 1);
            check_val("wr_b_latency", bv_cyc, req_last_cyc + 1);
        end else begin
            check_val("wr_decerr_noacc", acc_cnt - acc0, 0);
            check_val("wr_decerr_latency", bv_cyc, last_hs + 1);
        end
        repeat (b_dly) begin
            @(negedge ACLK);
            if (!BVALID || BRESP !== er) stable = 0;
        end
        check_val("wr_b_hold", stable, 1);
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
        check_val("wr_b_drop", BVALID, 0);
        check_val("wr_ready_back", {AWREADY, WREADY}, 2'b11);
        if (er == 2'b00) begin
            idx = int'(addr[11:2]);
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        @(negedge ACLK);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           input int dly, input bit err, input bit noack);
        bit ar_go = 0, ar_done = 0, stable = 1, in_rng;
        int ar_hs = 0, acc0, k, rv_cyc;
        logic [1:0]  er;
        logic [31:0] ed;
        rsp_delay = dly; rsp_err = err; rsp_noack = noack;
        in_rng = addr < WIN_SIZE;
        er     = exp_resp(in_rng, err, noack);
        ed     = !in_rng ? 32'h0 : (noack ? 32'hDEAD_BEEF : ref_mem[int'(addr[11:2])]);
        acc0   = acc_cnt;
        k      = 0;
        while (!ar_done && k < 100) begin
            @(negedge ACLK);
            if (ar_go) begin ARVALID = 0; ar_go = 0; ar_done = 1; end
            if (!ar_done && !ar_go && k >= ar_dly) begin
                ARVALID = 1; ARADDR = addr;
                if (ARREADY) begin ar_go = 1; ar_hs = cyc; end
            end
            k++;
        end
        check_val("rd_handshake", ar_done, 1);
        k = 0;
        while (!RVALID && k < 50) begin @(negedge ACLK); k++; end
        rv_cyc = cyc;
        check_val("rd_rvalid", RVALID, 1);
        check_val("rd_rresp", RRESP, er);
        check_val("rd_rdata", RDATA, ed);
        if (in_rng) begin
            check_val("rd_acc_cnt", acc_cnt - acc0, 1);
            check_val("rd_req_start", req_first_cyc, ar_hs + 1);
            check_val("rd_acc_fields", {acc_we, acc_addr, acc_wstb}, {1'b0, addr, 4'h0});
            check_val("rd_req_len", req_len, noack ? TO : dly + 1);
            check_val("rd_r_latency", rv_cyc, req_last_cyc + 1);
        end else begin
            check_val("rd_decerr_noacc", acc_cnt - acc0, 0);
            check_val("rd_decerr_latency", rv_cyc, ar_hs + 1);
        end
        repeat (r_dly) begin
            @(negedge ACLK);
            if (!RVALID || RRESP !== er || RDATA !== ed) stable = 0;
        end
        check_val("rd_r_hold", stable, 1);
        RREADY = 1;
        @(negedge ACLK);
        RREADY = 0;
        check_val("rd_r_drop", RVALID, 0);
        check_val("rd_ready_back", ARREADY, 1);
        @(negedge ACLK);
    endtask

    // Write and read presented together; the contention winner alternates
    task automatic rr_round(input logic [31:0] waddr, input logic [31:0] raddr, input logic [31:0] wdata);
        bit first_we;
        int k;
        first_we    = !prefer_read;
        prefer_read = !prefer_read;
        rsp_delay = 0; rsp_err = 0; rsp_noack = 0;
        we_log.delete();
        BREADY = 1; RREADY = 1;
        @(negedge ACLK);
        check_val("rr_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
        AWVALID = 1; AWADDR = waddr; WVALID = 1; WDATA = wdata; WSTRB = 4'hF;
        ARVALID = 1; ARADDR = raddr;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        k = 0;
        while (we_log.size() < 2 && k < 40) begin @(negedge ACLK); k++; end
        repeat (4) @(negedge ACLK);
        check_val("rr_count", we_log.size(), 2);
        if (we_log.size() == 2) begin
            check_val("rr_first", we_log[0], first_we);
            check_val("rr_second", we_log[1], !first_we);
        end
        ref_mem[int'(waddr[11:2])] = wdata;
        BREADY = 0; RREADY = 0;
        @(negedge ACLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        for (int i = 0; i < 1024; i++) begin
            dev_mem[i] = $urandom;
            ref_mem[i] = dev_mem[i];
        end
        repeat (2) @(negedge ACLK);
        check_val("rst_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, REG_REQ, REG_WE, BRESP, RRESP}, 0);
        check_val("rst_data", {RDATA, REG_ADDR}, 0);
        ARESET = 0;
        @(negedge ACLK);
        check_val("rdy_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

        rr_round(32'h100, 32'h104, 32'hCAFE_0001);
        rr_round(32'h108, 32'h10C, 32'hCAFE_0002);

        do_write(32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 2, 0, 0);
        do_write(32'h14, 32'h0BAD_F00D, 4'h5, 3, 0, 5, 1, 0, 0);
        do_write(32'h20, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 0);
        do_read(32'h20, 0, 2, 0, 0, 0);
        do_read(32'h2000, 0, 1, 0, 0, 0);
        do_write(32'h24, 32'h5555_AAAA, 4'hF, 0, 1, 0, 1, 1, 0);
        do_read(32'h28, 0, 0, 0, 0, 1);
        do_write(32'hFFC, 32'h7777_0000, 4'h0, 1, 0, 0, 7, 0, 0);
        do_write(32'h1000, 32'h1, 4'hF, 0, 0, 2, 0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 5) == 0) a = a + WIN_SIZE;
            d = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 5) == 0,
                         $urandom_range(0, 7) == 0);
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 7),
                        $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        // Reset asserted while a read waits on the local bus
        @(negedge ACLK);
        rsp_noack = 1; ARADDR = 32'h40; ARVALID = 1;
        @(negedge ACLK);
        ARVALID = 0;
        check_val("mid_req_up", REG_REQ, 1);
        repeat (2) @(negedge ACLK);
        #1 ARESET = 1;
        #1;
        check_val("mid_rst_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, REG_REQ, REG_WE, BRESP, RRESP}, 0);
        check_val("mid_rst_addr", {RDATA, REG_ADDR}, 0);
        check_val("mid_rst_wr", {REG_WDATA, REG_WSTB}, 0);
        @(negedge ACLK);
        ARESET = 0; rsp_noack = 0;
        @(negedge ACLK);
        check_val("mid_rdy_back", {AWREADY, WREADY, ARREADY}, 3'b111);
        check_val("mid_no_stale", {BVALID, RVALID, REG_REQ}, 3'b000);
        do_write(32'h44, 32'h0DD0_1234, 4'hF, 0, 0, 0, 0, 0, 0);
        do_read(32'h44, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
